// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the two-port SDRAM arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, ACTIVE, DONE)
//   PORT_VGA    : index of the framebuffer fetch port (fixed priority)
//   PORT_UART   : index of the UART loader port
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACTIVE,
    ST_DONE
  } arb_state_e;

  localparam logic PORT_VGA  = 1'b0;
  localparam logic PORT_UART = 1'b1;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of every requester-side and controller-side signal of the arbiter.
//   i_req*/i_rw*/i_addr*/i_data* : requester commands (held until ack)
//   o_ack*/o_rvalid*/o_rdata     : completion pulse and read beat return
//   o_sd_*                       : command towards the SDRAM controller
//   i_sd_*                       : controller read data, valid and busy
// modport slave  : the arbiter's view
// modport master : the view of the requesters plus controller together
interface sdram_port_arbiter_if #(
  parameter int unsigned WordLength   = 16,
  parameter int unsigned AddressWidth = 24
);

  logic                    i_req0;
  logic                    i_req1;
  logic                    i_rw0;
  logic                    i_rw1;
  logic [AddressWidth-1:0] i_addr0;
  logic [AddressWidth-1:0] i_addr1;
  logic [WordLength-1:0]   i_data0;
  logic [WordLength-1:0]   i_data1;
  logic                    o_ack0;
  logic                    o_ack1;
  logic                    o_rvalid0;
  logic                    o_rvalid1;
  logic [WordLength-1:0]   o_rdata;
  logic                    o_sd_enable;
  logic                    o_sd_rw;
  logic [AddressWidth-1:0] o_sd_addr;
  logic [WordLength-1:0]   o_sd_data;
  logic [WordLength-1:0]   i_sd_data;
  logic                    i_sd_valid;
  logic                    i_sd_busy;

  modport slave (
    input  i_req0, i_req1, i_rw0, i_rw1, i_addr0, i_addr1, i_data0, i_data1,
    input  i_sd_data, i_sd_valid, i_sd_busy,
    output o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_rdata,
    output o_sd_enable, o_sd_rw, o_sd_addr, o_sd_data
  );

  modport master (
    output i_req0, i_req1, i_rw0, i_rw1, i_addr0, i_addr1, i_data0, i_data1,
    output i_sd_data, i_sd_valid, i_sd_busy,
    input  o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_rdata,
    input  o_sd_enable, o_sd_rw, o_sd_addr, o_sd_data
  );

endinterface

// File: rtl/sdram_grant_select.sv
// Grant decision for the two requesters with an anti-starvation streak.
//   CLK, RST  : clock, synchronous active-high reset
//   req0/req1 : pending requests from the VGA and UART ports
//   grant_now : strobe, the arbiter commits the current decision this cycle
//   winner    : port that wins if a grant is taken now
//   valid     : at least one request is pending
// Port 0 wins by default; once it has been granted MaxStreak times in a row
// while port 1 waited, port 1 gets the next grant.
module sdram_grant_select
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxStreak = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic req0,
  input  logic req1,
  input  logic grant_now,
  output logic winner,
  output logic valid
);

  localparam int unsigned StreakW = $clog2(MaxStreak + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxStreak);

  logic [StreakW-1:0] streak_q;

  always_comb begin
    valid  = req0 | req1;
    winner = PORT_UART;
    if (req0 && !(req1 && (streak_q == StreakMax))) begin
      winner = PORT_VGA;
    end
  end

  // The streak only grows while port 1 is actually waiting; any grant that
  // leaves nobody waiting, or that serves port 1, starts a fresh streak.
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_q <= '0;
    end else if (grant_now && valid) begin
      if ((winner == PORT_VGA) && req1) begin
        if (streak_q != StreakMax) begin
          streak_q <= streak_q + 1'b1;
        end
      end else begin
        streak_q <= '0;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port front end for the SDRAM controller user side.
//   CLK : clock shared with the controller
//   RST : synchronous active-high reset
//   bus : sdram_port_arbiter_if slave view; requester ports 0 (VGA fetch)
//         and 1 (UART loader), plus the controller command/return signals
// One owner is granted in IDLE, a single enable is issued in ISSUE, read
// beats are forwarded to the owner while the controller is busy, and the
// owner receives a one-cycle ack in DONE.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned WordLength      = 16,
  parameter int unsigned AddressWidth    = 24,
  parameter int unsigned ReadBurstLength = 8,
  parameter int unsigned MaxStreak       = 4
) (
  input logic                  CLK,
  input logic                  RST,
  sdram_port_arbiter_if.slave  bus
);

  localparam int unsigned BeatW = $clog2(ReadBurstLength + 1);
  localparam logic [BeatW-1:0] BeatMax = BeatW'(ReadBurstLength);

  arb_state_e              state_q;
  arb_state_e              state_d;
  logic                    owner_q;
  logic                    grant_now;
  logic                    grant_winner;
  logic                    grant_valid;
  logic                    sd_enable;
  logic                    ack0;
  logic                    ack1;
  logic                    sel_rw;
  logic [AddressWidth-1:0] sel_addr;
  logic [WordLength-1:0]   sel_data;
  logic                    beat_in;
  logic                    rvalid0_q;
  logic                    rvalid1_q;
  logic [WordLength-1:0]   rdata_q;
  logic [BeatW-1:0]        beat_cnt_q;

  sdram_grant_select #(
    .MaxStreak(MaxStreak)
  ) u_grant_select (
    .CLK       (CLK),
    .RST       (RST),
    .req0      (bus.i_req0),
    .req1      (bus.i_req1),
    .grant_now (grant_now),
    .winner    (grant_winner),
    .valid     (grant_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_VGA;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        owner_q <= grant_winner;
      end
    end
  end

  // Enable is gated with busy so it drops in the very cycle the controller
  // accepts the command, giving exactly one enable per transaction.
  always_comb begin
    state_d   = state_q;
    grant_now = 1'b0;
    sd_enable = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid && !bus.i_sd_busy) begin
          grant_now = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.i_sd_busy) begin
          state_d = ST_ACTIVE;
        end else begin
          sd_enable = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!bus.i_sd_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ack0    = (owner_q == PORT_VGA);
        ack1    = (owner_q == PORT_UART);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (owner_q == PORT_UART) begin
      sel_rw   = bus.i_rw1;
      sel_addr = bus.i_addr1;
      sel_data = bus.i_data1;
    end else begin
      sel_rw   = bus.i_rw0;
      sel_addr = bus.i_addr0;
      sel_data = bus.i_data0;
    end
  end

  // Beats are only accepted while a read command is in flight.
  assign beat_in = ((state_q == ST_ISSUE) || (state_q == ST_ACTIVE)) &&
                   sel_rw && bus.i_sd_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      rvalid0_q <= beat_in && (owner_q == PORT_VGA);
      rvalid1_q <= beat_in && (owner_q == PORT_UART);
      if (beat_in) begin
        rdata_q <= bus.i_sd_data;
      end
      if (grant_now) begin
        beat_cnt_q <= '0;
      end else if (beat_in && (beat_cnt_q != BeatMax)) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  assign bus.o_sd_enable = sd_enable;
  assign bus.o_sd_rw     = sel_rw;
  assign bus.o_sd_addr   = sel_addr;
  assign bus.o_sd_data   = sel_data;
  assign bus.o_ack0      = ack0;
  assign bus.o_ack1      = ack1;
  assign bus.o_rvalid0   = rvalid0_q;
  assign bus.o_rvalid1   = rvalid1_q;
  assign bus.o_rdata     = rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural SDRAM controller:
// busy rises one cycle after enable and lasts 20 cycles, read beats carry
// 0x1000 + beat index.
module tb_sdram_port_arbiter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int unsigned total = 0;
  int unsigned bad   = 0;

  sdram_port_arbiter_if #(.WordLength(16), .AddressWidth(24)) bus();

  sdram_port_arbiter #(
    .WordLength(16),
    .AddressWidth(24),
    .ReadBurstLength(8),
    .MaxStreak(4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Controller model
  logic        busy_m;
  logic        hold_busy;
  logic        spurious;
  logic        m_rw;
  int unsigned cnt;
  int unsigned beat;
  int unsigned nbeats;

  assign bus.i_sd_busy = busy_m | hold_busy;

  always @(posedge CLK) begin
    if (RST) begin
      busy_m         <= 1'b0;
      cnt            <= 0;
      beat           <= 0;
      m_rw           <= 1'b0;
      bus.i_sd_valid <= 1'b0;
      bus.i_sd_data  <= 16'h0;
    end else begin
      bus.i_sd_valid <= 1'b0;
      if (bus.o_sd_enable && !busy_m) begin
        busy_m <= 1'b1;
        cnt    <= 20;
        beat   <= 0;
        m_rw   <= bus.o_sd_rw;
      end else if (busy_m) begin
        cnt <= cnt - 1;
        if (cnt == 1) busy_m <= 1'b0;
        if (cnt <= 18 && beat < nbeats && (m_rw || spurious)) begin
          bus.i_sd_valid <= 1'b1;
          bus.i_sd_data  <= 16'h1000 + 16'(beat);
          beat           <= beat + 1;
        end
      end
    end
  end

  // Output monitor (free-running tallies; tests take differences)
  int unsigned en_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  logic [15:0] rd_log[$];
  bit          ack_order[$];

  always @(negedge CLK) begin
    if (bus.o_sd_enable === 1'b1) en_cnt <= en_cnt + 1;
    if (bus.o_rvalid0 === 1'b1) begin
      rv0_cnt <= rv0_cnt + 1;
      rd_log.push_back(bus.o_rdata);
    end
    if (bus.o_rvalid1 === 1'b1) rv1_cnt <= rv1_cnt + 1;
    if (bus.o_ack0 === 1'b1) begin
      ack0_cnt <= ack0_cnt + 1;
      ack_order.push_back(1'b0);
    end
    if (bus.o_ack1 === 1'b1) begin
      ack1_cnt <= ack1_cnt + 1;
      ack_order.push_back(1'b1);
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_ack(input bit port, input int unsigned limit, output bit got);
    got = 1'b0;
    for (int unsigned i = 0; i < limit && !got; i++) begin
      step();
      if ((port == 1'b0 && bus.o_ack0 === 1'b1) || (port == 1'b1 && bus.o_ack1 === 1'b1))
        got = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    total++; if (bus.o_sd_enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b want=0", bus.o_sd_enable); end
    total++; if (bus.o_ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack0 got=%b want=0", bus.o_ack0); end
    total++; if (bus.o_ack1 !== 1'b0) begin bad++; $display("FAIL reset_ack1 got=%b want=0", bus.o_ack1); end
    total++; if (bus.o_rvalid0 !== 1'b0) begin bad++; $display("FAIL reset_rvalid0 got=%b want=0", bus.o_rvalid0); end
    total++; if (bus.o_rvalid1 !== 1'b0) begin bad++; $display("FAIL reset_rvalid1 got=%b want=0", bus.o_rvalid1); end
    total++; if (bus.o_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0000", bus.o_rdata); end
    RST = 1'b0;
    step();
  endtask

  task automatic test_read_port0();
    int unsigned e0 = en_cnt, r0 = rv0_cnt, r1 = rv1_cnt, a0 = ack0_cnt;
    int unsigned base = rd_log.size();
    bit got;
    logic [15:0] d;
    bus.i_req0 = 1'b1; bus.i_rw0 = 1'b1; bus.i_addr0 = 24'h000100; bus.i_data0 = 16'h0;
    wait_ack(1'b0, 100, got);
    bus.i_req0 = 1'b0;
    repeat (4) step();
    total++; if (!got) begin bad++; $display("FAIL rd0_ack_timeout got=0 want=1"); end
    total++; if (en_cnt - e0 != 1) begin bad++; $display("FAIL rd0_enables got=%0d want=1", en_cnt - e0); end
    total++; if (rv0_cnt - r0 != 8) begin bad++; $display("FAIL rd0_beats got=%0d want=8", rv0_cnt - r0); end
    for (int unsigned i = 0; i < 8; i++) begin
      d = (rd_log.size() > base + i) ? rd_log[base + i] : 16'hxxxx;
      total++; if (d !== 16'h1000 + 16'(i)) begin bad++; $display("FAIL rd0_data%0d got=%h want=%h", i, d, 16'h1000 + 16'(i)); end
    end
    total++; if (ack0_cnt - a0 != 1) begin bad++; $display("FAIL rd0_ack0_count got=%0d want=1", ack0_cnt - a0); end
    total++; if (rv1_cnt != r1) begin bad++; $display("FAIL rd0_rvalid1 got=%0d want=0", rv1_cnt - r1); end
  endtask

  task automatic test_write_port1();
    int unsigned e0 = en_cnt, r0 = rv0_cnt, r1 = rv1_cnt, a1 = ack1_cnt;
    int unsigned busy_cycles = 0, mis = 0;
    bit got = 1'b0;
    spurious = 1'b1;
    bus.i_req1 = 1'b1; bus.i_rw1 = 1'b0; bus.i_addr1 = 24'h3FFFFF; bus.i_data1 = 16'hA5A5;
    for (int unsigned i = 0; i < 100 && !got; i++) begin
      step();
      if (bus.i_sd_busy === 1'b1 || bus.o_sd_enable === 1'b1) begin
        if (bus.i_sd_busy === 1'b1) busy_cycles++;
        if (bus.o_sd_rw !== 1'b0 || bus.o_sd_data !== 16'hA5A5 || bus.o_sd_addr !== 24'h3FFFFF) mis++;
      end
      if (bus.o_ack1 === 1'b1) got = 1'b1;
    end
    bus.i_req1 = 1'b0;
    repeat (4) step();
    spurious = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL wr1_ack_timeout got=0 want=1"); end
    total++; if (mis != 0) begin bad++; $display("FAIL wr1_cmd_fields bad_cycles=%0d want=0", mis); end
    total++; if (busy_cycles != 20) begin bad++; $display("FAIL wr1_busy_cycles got=%0d want=20", busy_cycles); end
    total++; if (en_cnt - e0 != 1) begin bad++; $display("FAIL wr1_enables got=%0d want=1", en_cnt - e0); end
    total++; if (ack1_cnt - a1 != 1) begin bad++; $display("FAIL wr1_ack1_count got=%0d want=1", ack1_cnt - a1); end
    total++; if (rv0_cnt != r0 || rv1_cnt != r1) begin bad++; $display("FAIL wr1_rvalid got=%0d/%0d want=0/0", rv0_cnt - r0, rv1_cnt - r1); end
  endtask

  task automatic test_streak();
    int unsigned base = ack_order.size();
    bit exp_order[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit g;
    bus.i_req0 = 1'b1; bus.i_rw0 = 1'b1; bus.i_addr0 = 24'h000010;
    bus.i_req1 = 1'b1; bus.i_rw1 = 1'b0; bus.i_addr1 = 24'h000020; bus.i_data1 = 16'h5A5A;
    for (int unsigned i = 0; i < 400; i++) begin
      step();
      if (bus.o_ack1 === 1'b1) bus.i_req1 = 1'b0;
      if (ack_order.size() - base >= 6) break;
    end
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    repeat (4) step();
    total++; if (ack_order.size() - base != 6) begin bad++; $display("FAIL streak_grants got=%0d want=6", ack_order.size() - base); end
    for (int unsigned i = 0; i < 6; i++) begin
      g = (ack_order.size() > base + i) ? ack_order[base + i] : 1'b1;
      total++; if (g !== exp_order[i]) begin bad++; $display("FAIL streak_order%0d got=%0d want=%0d", i, g, exp_order[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int unsigned a0, a1, r0;
    bit got = 1'b0;
    bus.i_req0 = 1'b1; bus.i_rw0 = 1'b1; bus.i_addr0 = 24'h000300;
    for (int unsigned i = 0; i < 10 && !got; i++) begin
      step();
      if (bus.i_sd_busy === 1'b1) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL rst_busy_timeout got=0 want=1"); end
    repeat (12) step();
    RST = 1'b1;
    bus.i_req0 = 1'b0;
    step();
    total++; if (bus.o_sd_enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b want=0", bus.o_sd_enable); end
    total++; if (bus.o_ack0 !== 1'b0 || bus.o_ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b%b want=00", bus.o_ack0, bus.o_ack1); end
    total++; if (bus.o_rvalid0 !== 1'b0 || bus.o_rvalid1 !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b%b want=00", bus.o_rvalid0, bus.o_rvalid1); end
    total++; if (bus.o_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0000", bus.o_rdata); end
    RST = 1'b0;
    a0 = ack0_cnt; a1 = ack1_cnt;
    repeat (40) step();
    total++; if (ack0_cnt != a0 || ack1_cnt != a1) begin bad++; $display("FAIL rst_no_ack got=%0d want=0", (ack0_cnt - a0) + (ack1_cnt - a1)); end
    r0 = rv0_cnt;
    bus.i_req0 = 1'b1; bus.i_addr0 = 24'h000400;
    wait_ack(1'b0, 100, got);
    bus.i_req0 = 1'b0;
    repeat (4) step();
    total++; if (!got) begin bad++; $display("FAIL rst_after_ack got=0 want=1"); end
    total++; if (rv0_cnt - r0 != 8) begin bad++; $display("FAIL rst_after_beats got=%0d want=8", rv0_cnt - r0); end
  endtask

  task automatic test_busy_wait();
    int unsigned e0;
    bit got;
    hold_busy = 1'b1;
    step();
    e0 = en_cnt;
    bus.i_req1 = 1'b1; bus.i_rw1 = 1'b0; bus.i_addr1 = 24'h000200; bus.i_data1 = 16'h1234;
    repeat (6) step();
    total++; if (en_cnt != e0) begin bad++; $display("FAIL busy_no_enable got=%0d want=0", en_cnt - e0); end
    hold_busy = 1'b0;
    step();
    total++; if (bus.o_sd_enable !== 1'b1) begin bad++; $display("FAIL busy_grant_latency enable=%b want=1", bus.o_sd_enable); end
    wait_ack(1'b1, 100, got);
    bus.i_req1 = 1'b0;
    repeat (4) step();
    total++; if (!got) begin bad++; $display("FAIL busy_ack_timeout got=0 want=1"); end
  endtask

  task automatic test_short_burst();
    int unsigned r0 = rv0_cnt, a0 = ack0_cnt;
    bit got;
    nbeats = 5;
    bus.i_req0 = 1'b1; bus.i_rw0 = 1'b1; bus.i_addr0 = 24'h000040;
    wait_ack(1'b0, 100, got);
    bus.i_req0 = 1'b0;
    step();
    total++; if (!got) begin bad++; $display("FAIL short_ack_timeout got=0 want=1"); end
    total++; if (rv0_cnt - r0 != 5) begin bad++; $display("FAIL short_beats got=%0d want=5", rv0_cnt - r0); end
    total++; if (ack0_cnt - a0 != 1) begin bad++; $display("FAIL short_ack0_count got=%0d want=1", ack0_cnt - a0); end
    nbeats = 8;
    r0 = rv0_cnt;
    bus.i_req0 = 1'b1; bus.i_addr0 = 24'h000080;
    wait_ack(1'b0, 100, got);
    bus.i_req0 = 1'b0;
    repeat (4) step();
    total++; if (!got) begin bad++; $display("FAIL short_next_timeout got=0 want=1"); end
    total++; if (rv0_cnt - r0 != 8) begin bad++; $display("FAIL short_next_beats got=%0d want=8", rv0_cnt - r0); end
  endtask

  initial begin
    RST = 1'b1;
    hold_busy = 1'b0; spurious = 1'b0; nbeats = 8;
    bus.i_req0 = 1'b0; bus.i_rw0 = 1'b0; bus.i_addr0 = '0; bus.i_data0 = '0;
    bus.i_req1 = 1'b0; bus.i_rw1 = 1'b0; bus.i_addr1 = '0; bus.i_data1 = '0;
    test_reset();
    test_read_port0();
    test_write_port1();
    test_streak();
    test_mid_reset();
    test_busy_wait();
    test_short_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
